dstack_spill: RTL

Backing-store controller for the core0 data stack. It catches words evicted from the bottom of the on-chip dstack and writes them to a word-addressed memory region. It returns those words in LIFO order when the stack drains. A one-word cache and idle-time prefetch keep a fill to one cycle whenever possible. Overflow and underflow of the backing region are reported as fault pulses, the same way the dstack reports its own.

---
 rtl/dstack_spill_if.sv | 23 ++
 rtl/dstack_spill.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dstack_spill_if.sv
// Word-addressed memory port used by the data-stack spill controller.
// The controller drives it through the master modport; the memory sits on slave.
interface dstack_spill_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_ack;
  logic [WIDTH-1:0]      mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dstack_spill.sv
// Backing store for the core0 data stack: spills evicted words to memory and
// returns them LIFO, keeping the shallowest word in a one-entry cache.
module dstack_spill #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE       = 0,
  parameter int CAPACITY   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  spill_valid,
  input  logic [WIDTH-1:0]      spill_data,
  output logic                  spill_ready,
  input  logic                  fill_req,
  output logic                  fill_valid,
  output logic [WIDTH-1:0]      fill_data,
  dstack_spill_if.master        mem,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  overflow,
  output logic                  underflow
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, PREFETCH} state_e;

  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CAP_C    = (ADDR_WIDTH+1)'(CAPACITY);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  cached_q, cached_d;
  logic [WIDTH-1:0]      cache_q, cache_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  fill_valid_q, fill_valid_d;
  logic [WIDTH-1:0]      fill_data_q, fill_data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [ADDR_WIDTH-1:0] push_addr, top_addr;

  // Region addresses wrap modulo 2^ADDR_WIDTH by construction of the width.
  assign push_addr = BASE_A + count_q[ADDR_WIDTH-1:0];
  assign top_addr  = push_addr - ADDR_ONE;

  assign spill_ready   = (state_q == IDLE) && !fill_req && !clear;
  assign depth         = count_q + {{ADDR_WIDTH{1'b0}}, cached_q};
  assign fill_valid    = fill_valid_q;
  assign fill_data     = fill_data_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  always_comb begin
    // NOTE: every signal gets its hold/default value first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d      = state_q;
    count_d      = count_q;
    cached_d     = cached_q;
    cache_d      = cache_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fill_valid_d = 1'b0;
    fill_data_d  = fill_data_q;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      count_d     = '0;
      cached_d    = 1'b0;
      cache_d     = '0;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      fill_data_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A fill_req still high during the fill_valid cycle is the tail of
          // the request just served, not a new one.
          if (fill_req && !fill_valid_q) begin
            if (cached_q) begin
              fill_data_d  = cache_q;
              fill_valid_d = 1'b1;
              cached_d     = 1'b0;
            end else if (count_q != '0) begin
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = top_addr;
              state_d    = READ;
            end else begin
              underflow_d = 1'b1;
            end
          end else if (!fill_req) begin
            if (spill_valid) begin
              if (!cached_q) begin
                cache_d  = spill_data;
                cached_d = 1'b1;
              end else if (count_q < CAP_C) begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = push_addr;
                mem_wdata_d = cache_q;
                cache_d     = spill_data;
                state_d     = WRITE;
              end else begin
                overflow_d = 1'b1;
              end
            end else if (!cached_q && count_q != '0) begin
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = top_addr;
              state_d    = PREFETCH;
            end
          end
        end
        WRITE: if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          count_d   = count_q + CNT_ONE;
          state_d   = IDLE;
        end
        READ: if (mem.mem_ack) begin
          mem_req_d    = 1'b0;
          fill_data_d  = mem.mem_rdata;
          fill_valid_d = 1'b1;
          count_d      = count_q - CNT_ONE;
          state_d      = IDLE;
        end
        PREFETCH: if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          cache_d   = mem.mem_rdata;
          cached_d  = 1'b1;
          count_d   = count_q - CNT_ONE;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      cached_q     <= 1'b0;
      cache_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_data_q  <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      cached_q     <= cached_d;
      cache_q      <= cache_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_valid_q <= fill_valid_d;
      fill_data_q  <= fill_data_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

endmodule
